// File: rtl/soc_miner_pkg.sv
// Shared types and constants for the soc_miner register-access bridges.
//   state_t      : regbus2axi4lite FSM states
//   RESP_*       : AXI4-lite BRESP/RRESP encodings
//   PROT_DEFAULT : AxPROT value driven on every request
package soc_miner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/regbus2axi4lite.sv
// regbus -> AXI4-lite initiator bridge. Accepts one single-beat register
// access at a time and replays it as an AXI4-lite write or read.
//
// Ports:
//   Clk, RESET                  : clock, synchronous active-high reset
//   addr_valid/reg_write        : request pulse and direction (1 = write)
//   reg_addr/reg_wdata          : request address and write data
//   reg_rdata/reg_ready/reg_error : completion data, pulse and error flag
//   busy                        : high while a request is in flight
//   m_aw*/m_w*/m_b*             : AXI4-lite write channels
//   m_ar*/m_r*                  : AXI4-lite read channels (m_rlast ignored)
module regbus2axi4lite
  import soc_miner_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      Clk,
  input  logic                      RESET,
  input  logic                      addr_valid,
  input  logic                      reg_write,
  input  logic [ADDR_WIDTH-1:0]     reg_addr,
  input  logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [DATA_WIDTH-1:0]     reg_rdata,
  output logic                      reg_ready,
  output logic                      reg_error,
  output logic                      busy,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [2:0]                m_arprot,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ready;
  logic                  r_error;
  logic                  r_busy;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_aw_done;
  logic                  r_w_done;

  logic w_aw_fin;
  logic w_w_fin;
  logic w_unused;

  // Only bit 1 of a response distinguishes error from success; RLAST is
  // meaningless for single-beat AXI4-lite reads.
  assign w_unused = ^{m_rlast, m_bresp[0], m_rresp[0]};

  // AW and W finish independently; each counts as finished once its own
  // handshake has been seen, either now or in an earlier cycle.
  assign w_aw_fin = r_aw_done | (r_awvalid & m_awready);
  assign w_w_fin  = r_w_done  | (r_wvalid  & m_wready);

  always_ff @(posedge Clk) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (addr_valid) begin
            r_addr  <= reg_addr;
            r_wdata <= reg_wdata;
            r_busy  <= 1'b1;
            if (reg_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (r_awvalid && m_awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && m_wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Later assignments to the done flags win, so they are cleared
          // ready for the next write even when a handshake lands this cycle.
          if (w_aw_fin && w_w_fin) begin
            r_bready  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_bvalid && r_bready) begin
            r_error  <= m_bresp[1];
            r_bready <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          if (r_arvalid && m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_rvalid && r_rready) begin
            r_rdata  <= m_rdata;
            r_error  <= m_rresp[1];
            r_rready <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reg_rdata = r_rdata;
  assign reg_ready = r_ready;
  assign reg_error = r_error;
  assign busy      = r_busy;
  assign m_awvalid = r_awvalid;
  assign m_awaddr  = r_addr;
  assign m_awprot  = PROT_DEFAULT;
  assign m_wvalid  = r_wvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = '1;
  assign m_bready  = r_bready;
  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_addr;
  assign m_arprot  = PROT_DEFAULT;
  assign m_rready  = r_rready;

endmodule

// File: tb/tb_regbus2axi4lite.sv
module tb_regbus2axi4lite;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          Clk = 1'b0;
  logic          RESET;
  logic          addr_valid, reg_write;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          reg_ready, reg_error, busy;
  logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic          m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
  logic          m_bvalid = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b1;
  logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;
  logic [DW-1:0] m_rdata = '0;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic [2:0]    m_awprot, m_arprot;

  regbus2axi4lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .RESET(RESET),
    .addr_valid(addr_valid), .reg_write(reg_write), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ready(reg_ready), .reg_error(reg_error), .busy(busy),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- behavioural slave + protocol monitor ----------------
  int          cfg_aw_d = 0, cfg_w_d = 0, cfg_ar_d = 0, cfg_b_d = 0, cfg_r_d = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  int aw_wait = 0, w_wait = 0, ar_wait = 0;
  bit aw_done_f = 0, w_done_f = 0, ar_done_f = 0, b_flag = 0, r_flag = 0;
  int aw_hs_c = -1, w_hs_c = -1, ar_hs_c = -1;
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_ready = 0, viol = 0;
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  bit p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

  // Values set at the falling edge of cycle k are what the DUT samples at
  // the rising edge that ends cycle k.
  always @(negedge Clk) begin
    if (RESET) begin
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      aw_done_f = 0; w_done_f = 0; ar_done_f = 0; b_flag = 0; r_flag = 0;
      p_awv = 0; p_wv = 0; p_arv = 0; p_awhs = 0; p_whs = 0; p_arhs = 0;
    end else begin
      if (p_awv && !p_awhs && (!m_awvalid || m_awaddr !== p_awaddr)) viol++;
      if (p_wv && !p_whs && (!m_wvalid || m_wdata !== p_wdata)) viol++;
      if (p_arv && !p_arhs && (!m_arvalid || m_araddr !== p_araddr)) viol++;
      if (m_bready && !(aw_done_f && w_done_f)) viol++;
      if (m_rready && !ar_done_f) viol++;
      if (reg_ready) n_ready++;

      p_awhs = 0; m_awready = 0;
      if (m_awvalid) begin
        aw_cyc++;
        if (aw_wait >= cfg_aw_d) begin
          m_awready = 1; p_awhs = 1; aw_done_f = 1; aw_hs_c = cyc;
          cap_awaddr = m_awaddr; n_aw++; aw_wait = 0;
        end else aw_wait++;
      end
      p_whs = 0; m_wready = 0;
      if (m_wvalid) begin
        w_cyc++;
        if (w_wait >= cfg_w_d) begin
          m_wready = 1; p_whs = 1; w_done_f = 1; w_hs_c = cyc;
          cap_wdata = m_wdata; n_w++; w_wait = 0;
        end else w_wait++;
      end
      p_arhs = 0; m_arready = 0;
      if (m_arvalid) begin
        ar_cyc++;
        if (ar_wait >= cfg_ar_d) begin
          m_arready = 1; p_arhs = 1; ar_done_f = 1; ar_hs_c = cyc;
          cap_araddr = m_araddr; n_ar++; ar_wait = 0;
        end else ar_wait++;
      end

      if (b_flag) begin
        m_bvalid = 0; b_flag = 0; aw_done_f = 0; w_done_f = 0;
      end else if (!m_bvalid && aw_done_f && w_done_f &&
                   cyc >= imax(aw_hs_c, w_hs_c) + 1 + cfg_b_d) begin
        m_bvalid = 1; m_bresp = cfg_resp;
      end
      if (m_bvalid && m_bready) begin b_flag = 1; n_b++; end

      if (r_flag) begin
        m_rvalid = 0; r_flag = 0; ar_done_f = 0;
      end else if (!m_rvalid && ar_done_f && cyc >= ar_hs_c + 1 + cfg_r_d) begin
        m_rvalid = 1; m_rresp = cfg_resp; m_rdata = cfg_rdata;
      end
      if (m_rvalid && m_rready) begin r_flag = 1; n_r++; end

      p_awv = m_awvalid; p_awaddr = m_awaddr;
      p_wv  = m_wvalid;  p_wdata  = m_wdata;
      p_araddr = m_araddr; p_arv = m_arvalid;
    end
  end

  // ---------------- reference expectations ----------------
  logic [31:0] exp_rdata = '0;

  task automatic txn(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input int awd, input int wd, input int ard, input int bd, input int rd,
                     input logic [1:0] resp, input logic [31:0] rdat, input bit poke);
    int c0, rc, exp_rc;
    int s_aw, s_w, s_ar, s_b, s_r, s_awc, s_wc, s_arc, s_rdy;
    cfg_aw_d = awd; cfg_w_d = wd; cfg_ar_d = ard; cfg_b_d = bd; cfg_r_d = rd;
    cfg_resp = resp; cfg_rdata = rdat;
    s_aw = n_aw; s_w = n_w; s_ar = n_ar; s_b = n_b; s_r = n_r;
    s_awc = aw_cyc; s_wc = w_cyc; s_arc = ar_cyc; s_rdy = n_ready;
    c0 = cyc;
    addr_valid = 1; reg_write = wr; reg_addr = a; reg_wdata = d;
    @(negedge Clk);
    addr_valid = 0; reg_write = 0; reg_addr = '0; reg_wdata = '0;
    if (poke) begin
      @(negedge Clk);
      chk({tag, "_busy_before_poke"}, busy, 1);
      addr_valid = 1; reg_write = ~wr; reg_addr = 32'h40; reg_wdata = 32'hDEAD_BEEF;
      @(negedge Clk);
      addr_valid = 0; reg_write = 0; reg_addr = '0; reg_wdata = '0;
    end
    rc = -1;
    for (int i = 0; i < 300; i++) begin
      if (reg_ready) begin rc = cyc; break; end
      @(negedge Clk);
    end
    exp_rc = wr ? imax(c0 + 1 + awd, c0 + 1 + wd) + 2 + bd : c0 + 1 + ard + 2 + rd;
    chk({tag, "_ready_cycle"}, rc, exp_rc);
    if (!wr) exp_rdata = rdat;
    chk({tag, "_error"}, reg_error, resp[1]);
    chk({tag, "_rdata"}, reg_rdata, exp_rdata);
    chk({tag, "_busy_at_ready"}, busy, 1);
    if (wr) begin
      chk({tag, "_aw_hs_cycle"}, aw_hs_c, c0 + 1 + awd);
      chk({tag, "_w_hs_cycle"}, w_hs_c, c0 + 1 + wd);
      chk({tag, "_awaddr"}, cap_awaddr, a);
      chk({tag, "_wdata"}, cap_wdata, d);
    end else begin
      chk({tag, "_ar_hs_cycle"}, ar_hs_c, c0 + 1 + ard);
      chk({tag, "_araddr"}, cap_araddr, a);
    end
    @(negedge Clk);
    chk({tag, "_ready_single"}, reg_ready, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_n_aw"}, n_aw - s_aw, wr ? 1 : 0);
    chk({tag, "_n_w"}, n_w - s_w, wr ? 1 : 0);
    chk({tag, "_n_b"}, n_b - s_b, wr ? 1 : 0);
    chk({tag, "_n_ar"}, n_ar - s_ar, wr ? 0 : 1);
    chk({tag, "_n_r"}, n_r - s_r, wr ? 0 : 1);
    chk({tag, "_awvalid_cycles"}, aw_cyc - s_awc, wr ? awd + 1 : 0);
    chk({tag, "_wvalid_cycles"}, w_cyc - s_wc, wr ? wd + 1 : 0);
    chk({tag, "_arvalid_cycles"}, ar_cyc - s_arc, wr ? 0 : ard + 1);
    chk({tag, "_ready_pulses"}, n_ready - s_rdy, 1);
    chk({tag, "_protocol"}, viol, 0);
  endtask

  initial begin
    int s_rdy;
    bit seen;
    RESET = 1; addr_valid = 0; reg_write = 0; reg_addr = '0; reg_wdata = '0;
    repeat (3) @(negedge Clk);
    chk("rst_reg_ready", reg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_rdata", reg_rdata, 0);
    chk("rst_reg_error", reg_error, 0);
    chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
    chk("rst_readies", {m_bready, m_rready}, 0);
    chk("rst_addr_data", {m_awaddr, m_wdata}, 0);
    chk("rst_wstrb", m_wstrb, 4'hF);
    chk("rst_prot", {m_awprot, m_arprot}, 0);
    RESET = 0;
    @(negedge Clk);

    txn("wr_zero_wait", 1, 32'h8, 32'h1234_5678, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    txn("wr_aw_stall", 1, 32'hC, 32'hA5A5_0F0F, 3, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    txn("wr_w_stall", 1, 32'h10, 32'h0000_0001, 0, 2, 0, 1, 0, 2'b00, 32'h0, 0);
    txn("rd_stall", 0, 32'h4, 32'h0, 0, 0, 2, 0, 5, 2'b00, 32'hCAFE_F00D, 0);
    txn("rd_slverr", 0, 32'h14, 32'h0, 0, 0, 0, 0, 1, 2'b10, 32'h1111_2222, 0);
    txn("wr_decerr", 1, 32'h18, 32'h3333_4444, 1, 1, 0, 0, 0, 2'b11, 32'h0, 0);
    txn("rd_poke_busy", 0, 32'h1C, 32'h0, 0, 0, 2, 0, 5, 2'b00, 32'h5555_6666, 1);
    txn("wr_poke_busy", 1, 32'h20, 32'h7777_8888, 3, 4, 0, 2, 0, 2'b00, 32'h0, 1);

    // Reset while a read waits for its data phase.
    cfg_ar_d = 0; cfg_r_d = 30; cfg_resp = 2'b00; cfg_rdata = 32'h9999_AAAA;
    addr_valid = 1; reg_write = 0; reg_addr = 32'h24;
    @(negedge Clk);
    addr_valid = 0; reg_addr = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_rready) begin seen = 1; break; end
      @(negedge Clk);
    end
    chk("rst_mid_reached_rd_resp", seen, 1);
    @(negedge Clk);
    s_rdy = n_ready;
    RESET = 1;
    @(negedge Clk);
    chk("rst_mid_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
    chk("rst_mid_readies", {m_bready, m_rready}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_reg_ready", reg_ready, 0);
    @(negedge Clk);
    RESET = 0;
    repeat (40) @(negedge Clk);
    chk("rst_mid_no_ready_pulse", n_ready - s_rdy, 0);
    exp_rdata = '0;
    chk("rst_mid_rdata_cleared", reg_rdata, 0);
    txn("wr_after_reset", 1, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);

    for (int t = 0; t < 30; t++) begin
      bit          wr;
      logic [31:0] a, d, rdat;
      logic [1:0]  resp;
      wr   = 1'($urandom_range(0, 1));
      a    = $urandom() & 32'hFFFF_FFFC;
      d    = $urandom();
      rdat = $urandom();
      resp = 2'($urandom_range(0, 3));
      txn($sformatf("rand%0d", t), wr, a, d, $urandom_range(0, 4), $urandom_range(0, 4),
          $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), resp, rdat, 0);
      if ($urandom_range(0, 1) == 1) @(negedge Clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regbus2axi4lite.md
Name: regbus2axi4lite

Overview:
- AXI4-lite initiator bridge: takes single-beat regbus register accesses and issues them as AXI4-lite write or read transactions to a register slave.
- It is the opposite end of axi4lite2regbus.
- Used by on-chip sequencers, and in loopback benches, to drive soc_miner register space (go/source/destination/length) without an external host.
- One access outstanding at a time; strictly in order.

Parameters:
- ADDR_WIDTH, 32, AXI/regbus address width.
- DATA_WIDTH, 32, AXI/regbus data width; multiple of 8.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- addr_valid  in  1  regbus request pulse; sampled only when busy=0.
- reg_write  in  1  1=write, 0=read; qualified by addr_valid.
- reg_addr  in  ADDR_WIDTH  register byte address.
- reg_wdata  in  DATA_WIDTH  write data.
- reg_rdata  out  DATA_WIDTH  read data; valid while reg_ready=1.
- reg_ready  out  1  one-cycle completion pulse.
- reg_error  out  1  valid with reg_ready; 1 if BRESP/RRESP[1]=1 (SLVERR/DECERR).
- busy  out  1  1 from the cycle after acceptance through the reg_ready cycle.
- m_awvalid/m_awready/m_awaddr[ADDR_WIDTH]/m_awprot[3]: AXI4-lite write address channel.
- m_wvalid/m_wready/m_wdata[DATA_WIDTH]/m_wstrb[DATA_WIDTH/8]: write data channel.
- m_bvalid/m_bready/m_bresp[2]: write response channel.
- m_arvalid/m_arready/m_araddr[ADDR_WIDTH]/m_arprot[3]: read address channel.
- m_rvalid/m_rready/m_rdata[DATA_WIDTH]/m_rresp[2]/m_rlast[1]: read data channel; m_rlast is ignored.

Behaviour:
- Reset and constant outputs:
  - All outputs are registered and reset to 0; state resets to IDLE.
  - awprot/arprot are constant 3'b000; wstrb is constant all-ones.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - On addr_valid=1, capture addr and wdata into registers.
  - reg_write=1: go to WR_REQ with awvalid=wvalid=1 next cycle.
  - reg_write=0: go to RD_REQ with arvalid=1 next cycle.
- WR_REQ:
  - awvalid and wvalid complete independently. Each drops the cycle after its own valid&ready.
  - Both may complete in the same cycle, or in either order.
  - Go to WR_RESP once both have completed; bready=1 in WR_RESP.
- WR_RESP: on bvalid&bready, latch bresp[1] into reg_error, drop bready, go to DONE.
- RD_REQ: hold arvalid until arready, then go to RD_RESP with rready=1.
- RD_RESP: on rvalid&rready, latch rdata and rresp[1], drop rready, go to DONE.
- DONE:
  - reg_ready=1 for exactly one cycle; then back to IDLE.
  - reg_rdata keeps its last read value until the next read completes; writes leave it unchanged.
- AXI rules:
  - A valid, once asserted, never drops and its address/data never change before the handshake.
  - No combinational path from any ready input to any valid output.
- Requests while busy: addr_valid with busy=1 is ignored (dropped); the requester must watch busy.
  - The IDLE cycle after DONE accepts a new request.
- Latency with a zero-wait slave (ready=1, response one cycle after the handshake):
  - addr_valid at cycle 0, valid at cycle 1, response at cycle 2, reg_ready at cycle 3.
- Early responses: bvalid before both AW and W complete is not accepted; bready stays 0 until WR_RESP.
- Reset mid-transaction returns to IDLE and clears every valid/ready on the next edge. The system resets the slave simultaneously.

Decomposition:
- Shared package soc_miner_pkg holds:
  - the state enum typedef;
  - AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - the PROT_DEFAULT constant.
- Single module; no sub-module is natural. AW/W completion is tracked with two local done flags.

Test Plan:
- Write 0x8 <- 0x1234_5678, slave always ready, bresp=OKAY -> AW/W valid at cycle 1 with awaddr=0x8 and wdata=0x12345678; reg_ready at cycle 3; reg_error=0.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid and awaddr held stable 4 cycles; bready rises only after AW completes; exactly one reg_ready.
- Read 0x4, rdata=0xCAFE_F00D after arready stall of 2 and rvalid stall of 5 -> arvalid stable for 3 cycles; reg_rdata=0xCAFEF00D with reg_ready; reg_error=0.
- Read with rresp=SLVERR, then write with bresp=DECERR -> reg_error=1 on both reg_ready pulses.
- addr_valid pulsed while busy=1 -> no new AXI transaction issued; the first transaction completes unaffected.
- RESET asserted during RD_RESP with rvalid low -> next cycle all valids/readies=0, busy=0, reg_ready never pulses; a following write to 0x0 completes normally.
